// File: rtl/request_queue.sv
// Request queue between the trace parser and the scheduler.
// Accepts are gated on the parser's timestamp, entries retire in order, and each entry tracks its age.
package request_queue_pkg;
    localparam int ADDRESS_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_FETCH = 2'd2
    } parsed_op_t;

    typedef struct packed {
        logic                     op_ready_s;
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [31:0]              time_cpu;
    } parser_out_struct_t;

    typedef enum logic [1:0] {
        Q_EMPTY  = 2'd0,
        Q_ACTIVE = 2'd1,
        Q_FULL   = 2'd2
    } queue_state_t;
endpackage

module request_queue
    import request_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 16,
    parameter int AGE_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  parser_out_struct_t           in,
    output logic                         queue_full,
    output logic                         pending_request,
    input  logic                         pop,
    output logic                         out_valid,
    output parsed_op_t                   out_opcode,
    output logic [ADDRESS_WIDTH-1:0]     out_address,
    output logic [31:0]                  out_time,
    output logic [AGE_WIDTH-1:0]         out_age,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output queue_state_t                 state
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

    parsed_op_t               op_mem   [QUEUE_DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [QUEUE_DEPTH];
    logic [31:0]              time_mem [QUEUE_DEPTH];
    logic [AGE_WIDTH-1:0]     age_mem  [QUEUE_DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   cpu_time;
    logic [CW-1:0] count_next;
    queue_state_t  state_next;
    logic          accept;
    logic          retire;
    logic          skip;

    // Full is judged on the start-of-cycle count, so a pop never makes room for a same-cycle accept.
    assign accept = in.op_ready_s && (count < FULL_CNT) && (in.time_cpu <= cpu_time) && !rst;
    assign retire = pop && (count != '0) && !rst;
    assign skip   = (count == '0) && in.op_ready_s && (in.time_cpu > cpu_time) && !rst;

    assign pending_request = in.op_ready_s && !accept;

    always_comb begin
        count_next = count;
        if (accept && !retire)
            count_next = count + CW'(1);
        else if (!accept && retire)
            count_next = count - CW'(1);
    end

    always_comb begin
        state_next = Q_ACTIVE;
        if (rst || count_next == '0)
            state_next = Q_EMPTY;
        else if (count_next == FULL_CNT)
            state_next = Q_FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= Q_EMPTY;
            queue_full <= 1'b0;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            cpu_time   <= '0;
        end else begin
            state      <= state_next;
            queue_full <= (state_next == Q_FULL);
            count      <= count_next;
            if (accept)
                tail <= tail + PW'(1);
            if (retire)
                head <= head + PW'(1);
            // An idle queue jumps straight to the parser's timestamp instead of counting up to it.
            if (skip)
                cpu_time <= in.time_cpu;
            else if (cpu_time != '1)
                cpu_time <= cpu_time + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_mem[tail]   <= in.opcode;
            addr_mem[tail] <= in.address;
            time_mem[tail] <= cpu_time;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (rst)
                age_mem[i] <= '0;
            else if (accept && tail == PW'(i))
                age_mem[i] <= '0;
            else if (age_mem[i] != '1)
                age_mem[i] <= age_mem[i] + AGE_WIDTH'(1);
        end
    end

    assign out_valid   = (count != '0);
    assign out_opcode  = out_valid ? op_mem[head]   : OP_READ;
    assign out_address = out_valid ? addr_mem[head] : '0;
    assign out_time    = out_valid ? time_mem[head] : '0;
    assign out_age     = out_valid ? age_mem[head]  : '0;
endmodule
